dmem_port: RTL and testbench

Single-port data memory responder on the CPU load/store path. It accepts word-aligned requests carrying shifted store data and per-byte write enables, and performs byte-masked writes into a word-organised RAM. It returns raw 32-bit read words to the CPU-side load formatter, which does the shifting and sign extension. Each access uses a request/acknowledge handshake and has a programmable number of wait states for modelling slower memories.

---
 rtl/dmem_port.sv | 119 +++++++++++
 tb/tb_dmem_port.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_port.sv
// rtl/dmem_port.sv - byte-masked single-port data memory responder with wait states, optional DMEM_WE_CHECK_EN write-enable check
module dmem_port #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_we,
    input  logic [31:0] i_data_wr,
    output logic [31:0] o_data_rd,
    output logic        o_ack,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [31:0]           ram [2**ADDR_WIDTH];
    state_t                state;
    state_t                state_next;
    logic [3:0]            cnt;
    logic                  is_read;
    logic                  bad_we;
    logic [31:0]           rd_buf;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  accept;
    logic                  we_legal;
    logic                  wr_en;
    logic                  unused_addr_bits;

    assign word_idx         = i_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0]};
    assign accept           = (state == S_IDLE) && i_req;

`ifdef DMEM_WE_CHECK_EN
    always_comb begin
        we_legal = 1'b0;
        case (i_we)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: we_legal = 1'b1;
            default:                            we_legal = 1'b0;
        endcase
    end
`else
    assign we_legal = 1'b1;
`endif

    // Reset takes priority over acceptance, so no write lands in a reset cycle.
    assign wr_en = accept && i_rst_n && (i_we != 4'b0000) && we_legal;

    // RAM is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 4; n++) begin
            if (wr_en && i_we[n]) begin
                ram[word_idx][8*n +: 8] <= i_data_wr[8*n +: 8];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (i_req) state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (cnt == 4'd0) state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            is_read   <= 1'b0;
            bad_we    <= 1'b0;
            rd_buf    <= 32'h0;
            o_data_rd <= 32'h0;
            o_ack     <= 1'b0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state  <= state_next;
            o_ack  <= (state_next == S_RESP);
            o_busy <= (state_next != S_IDLE);
            o_err  <= (state_next == S_RESP) && (accept ? !we_legal : bad_we);

            if (accept) begin
                is_read <= (i_we == 4'b0000);
                bad_we  <= !we_legal;
                cnt     <= WAIT_LOAD;
                if (i_we == 4'b0000) begin
                    rd_buf <= ram[word_idx];
                end
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            // The visible read word only changes on the edge into the ack cycle.
            if (state_next == S_RESP) begin
                if (accept) begin
                    if (i_we == 4'b0000) begin
                        o_data_rd <= ram[word_idx];
                    end
                end else if (is_read) begin
                    o_data_rd <= rd_buf;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_port.sv
// tb/tb_dmem_port.sv - randomized self-checking bench for dmem_port with zero and three wait states
module tb_dmem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [2];
    logic [31:0] addr  [2];
    logic [3:0]  we    [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        busy  [2];
    logic        err   [2];

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem     [2][1024];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    dmem_port #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]), .i_addr(addr[0]),
        .i_we(we[0]), .i_data_wr(wdata[0]), .o_data_rd(rdata[0]),
        .o_ack(ack[0]), .o_busy(busy[0]), .o_err(err[0])
    );

    dmem_port #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]), .i_addr(addr[1]),
        .i_we(we[1]), .i_data_wr(wdata[1]), .o_data_rd(rdata[1]),
        .o_ack(ack[1]), .o_busy(busy[1]), .o_err(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit we_is_legal(input logic [3:0] w);
        logic [3:0] legal [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                  4'b1000, 4'b0011, 4'b1100, 4'b1111};
        foreach (legal[i]) if (w == legal[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_access(input int k, input logic [31:0] a, input logic [3:0] w,
                                input logic [31:0] d, output logic [31:0] exp_rd,
                                output logic exp_err);
        int idx = int'(a[11:2]);
        bit rejected = 1'b0;
`ifdef DMEM_WE_CHECK_EN
        rejected = !we_is_legal(w);
`endif
        exp_err = rejected;
        if (w == 4'b0000) begin
            last_rd[k] = mem[k][idx];
        end else if (!rejected) begin
            for (int n = 0; n < 4; n++) begin
                if (w[n]) mem[k][idx][8*n +: 8] = d[8*n +: 8];
            end
        end
        exp_rd = last_rd[k];
    endtask

    // Called at a falling edge with the instance idle; returns at a falling edge.
    task automatic do_access(input int k, input logic [31:0] a, input logic [3:0] w,
                             input logic [31:0] d, input string tag);
        int          wc = (k == 1) ? 3 : 0;
        logic [31:0] prev = last_rd[k];
        logic [31:0] exp_rd;
        logic        exp_err;
        model_access(k, a, w, d, exp_rd, exp_err);
        req[k] = 1'b1; addr[k] = a; we[k] = w; wdata[k] = d;
        @(posedge clk);
        #1;
        req[k] = 1'b0; addr[k] = $urandom; we[k] = 4'($urandom); wdata[k] = $urandom;
        for (int c = 1; c <= wc + 1; c++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy[k]), 32'd1);
            check({tag, "_ack"}, 32'(ack[k]), 32'(c == wc + 1));
            if (c == wc + 1) begin
                check({tag, "_err"}, 32'(err[k]), 32'(exp_err));
                check({tag, "_rdata"}, rdata[k], exp_rd);
            end else begin
                check({tag, "_hold"}, rdata[k], prev);
            end
        end
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy[k]), 32'd0);
        check({tag, "_idle_ack"}, 32'(ack[k]), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [9:0]  idx;
        logic [3:0]  w;

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; addr[k] = '0; we[k] = '0; wdata[k] = '0;
            last_rd[k] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_rdata", rdata[k], 32'h0);
            check("rst_ack", 32'(ack[k]), 32'd0);
            check("rst_busy", 32'(busy[k]), 32'd0);
            check("rst_err", 32'(err[k]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            do_access(k, 32'h10, 4'b1111, 32'hDEADBEEF, "wr10");
            do_access(k, 32'h10, 4'b0000, 32'h0, "rd10");
            check("deadbeef", rdata[k], 32'hDEADBEEF);

            do_access(k, 32'h20, 4'b1111, 32'h11223344, "wr20");
            do_access(k, 32'h23, 4'b1000, 32'hAA000000, "merge_wr");
            do_access(k, 32'h20, 4'b0000, 32'h0, "merge_rd");
            check("merge", rdata[k], 32'hAA223344);

            do_access(k, 32'h0000_1004, 4'b1111, 32'h5A5A5A5A, "alias_wr");
            do_access(k, 32'h0000_0004, 4'b0000, 32'h0, "alias_rd");
            check("alias", rdata[k], 32'h5A5A5A5A);

            do_access(k, 32'h30, 4'b1111, 32'h11223344, "wr30");
            do_access(k, 32'h30, 4'b0110, 32'h00BBCC00, "we0110");
            do_access(k, 32'h30, 4'b0000, 32'h0, "rd30");
`ifdef DMEM_WE_CHECK_EN
            check("we_check", rdata[k], 32'h11223344);
`else
            check("we_check", rdata[k], 32'h11BBCC44);
`endif
        end

        // Request held high on the three-wait-state instance: re-accepted right after ack.
        do_access(1, 32'h40, 4'b1111, 32'hCAFEF00D, "wr40");
        req[1] = 1'b1; addr[1] = 32'h40; we[1] = 4'b0000; wdata[1] = 32'h0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check("held_ack", 32'(ack[1]), 32'(i % 5 == 4));
            check("held_busy", 32'(busy[1]), 32'(i % 5 != 0));
            if (i % 5 == 4) check("held_rdata", rdata[1], 32'hCAFEF00D);
        end
        req[1] = 1'b0;
        @(negedge clk);
        check("held_end_busy", 32'(busy[1]), 32'd0);
        last_rd[1] = 32'hCAFEF00D;

        // Reset two cycles into a waited read: access is dropped without an ack.
        do_access(1, 32'h44, 4'b1111, 32'h12345678, "wr44");
        req[1] = 1'b1; addr[1] = 32'h44; we[1] = 4'b0000;
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", 32'(busy[1]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy[1]), 32'd0);
        check("abort_ack", 32'(ack[1]), 32'd0);
        check("abort_rdata", rdata[1], 32'h0);
        check("abort_rdata0", rdata[0], 32'h0);
        rst_n = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_late_ack", 32'(ack[1]), 32'd0);
        end
        do_access(1, 32'h44, 4'b0000, 32'h0, "post_rst");
        check("post_rst_val", rdata[1], 32'h12345678);

        // Randomized traffic over a pool of fully initialized words, with aliased upper bits.
        for (int k = 0; k < 2; k++) begin
            for (int i = 64; i < 80; i++) begin
                do_access(k, 32'(i) << 2, 4'b1111, $urandom, "seed");
            end
            for (int i = 0; i < 150; i++) begin
                r   = $urandom;
                idx = 10'(64 + $urandom_range(0, 15));
                w   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
                do_access(k, {r[31:12], idx, r[1:0]}, w, $urandom, "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
